// File: rtl/kf8255_port_pkg.sv
// Shared KF8255 port definitions: mode encoding, direction constants and the
// control-word mode decode.
package kf8255_port_pkg;

    typedef enum logic [1:0] {
        MODE_BASIC   = 2'd0,
        MODE_STROBED = 2'd1,
        MODE_BIDIR   = 2'd2
    } port_mode_e;

    localparam logic PORT_INPUT  = 1'b1;
    localparam logic PORT_OUTPUT = 1'b0;

    // Control-word values 2 and 3 both select bidirectional operation.
    function automatic port_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_BASIC;
            2'd1:    return MODE_STROBED;
            default: return MODE_BIDIR;
        endcase
    endfunction

endpackage

// File: rtl/kf8255_sync_fifo.sv
// Small synchronous FIFO with flush; a pop frees its slot for a push on the
// same edge, so push+pop on a full buffer both succeed.
module kf8255_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push && !flush)
            r_mem[r_wr_ptr] <= data_in;
    end

endmodule

// File: rtl/kf8255_strobed_port.sv
// One KF8255 port: mode/direction config, mode 1/2 STB/IBF and OBF/ACK
// handshakes with INTE/INTR, and a buffer in each direction.
module kf8255_strobed_port
    import kf8255_port_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_mode,
    input  logic [1:0]            mode_in,
    input  logic                  direction_in,
    input  logic                  inte_write,
    input  logic                  inte_sel,
    input  logic                  inte_value,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    input  logic [DATA_WIDTH-1:0] port_data_in,
    output logic [DATA_WIDTH-1:0] port_data_out,
    output logic                  port_data_oe,
    input  logic                  stb_n,
    input  logic                  ack_n,
    output logic                  ibf,
    output logic                  obf_n,
    output logic                  intr,
    output logic                  overrun
);
    port_mode_e              r_mode;
    logic                    r_dir;
    logic                    r_inte_in, r_inte_out;
    logic                    r_intr_in, r_intr_out;
    logic                    r_overrun;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [DATA_WIDTH-1:0]   r_pdo;
    logic [SYNC_STAGES-1:0]  r_stb_sync, r_ack_sync;
    logic                    r_stb_prev, r_ack_prev;

    logic                    w_stb_fall, w_stb_rise, w_ack_fall, w_ack_rise;
    logic                    w_in_hs, w_out_hs;
    logic                    w_in_push, w_in_pop, w_out_push, w_out_pop;
    logic                    w_in_full, w_in_empty, w_out_full, w_out_empty;
    logic [DATA_WIDTH-1:0]   w_in_head, w_out_head;
    logic                    w_drop;

    // Sync chains and edge trackers reset high so releasing reset never
    // looks like a strobe or acknowledge edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stb_sync <= '1;
            r_ack_sync <= '1;
            r_stb_prev <= 1'b1;
            r_ack_prev <= 1'b1;
        end else begin
            r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], stb_n};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_n};
            r_stb_prev <= r_stb_sync[SYNC_STAGES-1];
            r_ack_prev <= r_ack_sync[SYNC_STAGES-1];
        end
    end

    assign w_stb_fall = r_stb_prev & ~r_stb_sync[SYNC_STAGES-1];
    assign w_stb_rise = ~r_stb_prev & r_stb_sync[SYNC_STAGES-1];
    assign w_ack_fall = r_ack_prev & ~r_ack_sync[SYNC_STAGES-1];
    assign w_ack_rise = ~r_ack_prev & r_ack_sync[SYNC_STAGES-1];

    assign w_in_hs  = (r_mode == MODE_BIDIR) || (r_mode == MODE_STROBED && r_dir == PORT_INPUT);
    assign w_out_hs = (r_mode == MODE_BIDIR) || (r_mode == MODE_STROBED && r_dir == PORT_OUTPUT);

    assign w_in_push  = ~write_mode & w_in_hs & w_stb_fall;
    assign w_in_pop   = ~write_mode & w_in_hs & cpu_read & ~w_in_empty;
    assign w_out_push = ~write_mode & w_out_hs & cpu_write;
    assign w_out_pop  = ~write_mode & w_out_hs & w_ack_fall & ~w_out_empty;
    assign w_drop     = (w_in_push & w_in_full & ~w_in_pop) | (w_out_push & w_out_full & ~w_out_pop);

    kf8255_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_in_push),
        .pop     (w_in_pop),
        .flush   (write_mode),
        .data_in (port_data_in),
        .full    (w_in_full),
        .empty   (w_in_empty),
        .head    (w_in_head)
    );

    kf8255_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_out_push),
        .pop     (w_out_pop),
        .flush   (write_mode),
        .data_in (cpu_write_data),
        .full    (w_out_full),
        .empty   (w_out_empty),
        .head    (w_out_head)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode     <= MODE_BASIC;
            r_dir      <= PORT_INPUT;
            r_inte_in  <= 1'b0;
            r_inte_out <= 1'b0;
            r_intr_in  <= 1'b0;
            r_intr_out <= 1'b0;
            r_overrun  <= 1'b0;
            r_rd_data  <= '0;
            r_pdo      <= '0;
        end else if (write_mode) begin
            r_mode     <= decode_mode(mode_in);
            r_dir      <= direction_in;
            r_inte_in  <= 1'b0;
            r_inte_out <= 1'b0;
            r_intr_in  <= 1'b0;
            r_intr_out <= 1'b0;
            r_overrun  <= 1'b0;
            r_pdo      <= '0;
        end else begin
            if (inte_write) begin
                if (inte_sel) r_inte_out <= inte_value;
                else          r_inte_in  <= inte_value;
            end
            if (w_drop)
                r_overrun <= 1'b1;

            if (r_mode == MODE_BASIC && r_dir == PORT_INPUT)
                r_rd_data <= port_data_in;
            else if (r_mode == MODE_BASIC && cpu_read)
                r_rd_data <= r_pdo;
            else if (w_in_pop)
                r_rd_data <= w_in_head;

            // The last acknowledged byte stays on the pins once the buffer drains.
            if (r_mode == MODE_BASIC && r_dir == PORT_OUTPUT && cpu_write)
                r_pdo <= cpu_write_data;
            else if (w_out_pop)
                r_pdo <= w_out_head;

            if (w_in_hs && cpu_read)
                r_intr_in <= 1'b0;
            else if (w_in_hs && w_stb_rise && r_inte_in && !w_in_empty)
                r_intr_in <= 1'b1;

            if (w_out_hs && cpu_write)
                r_intr_out <= 1'b0;
            else if (w_out_hs && w_ack_rise && r_inte_out && w_out_empty)
                r_intr_out <= 1'b1;
        end
    end

    always_comb begin
        port_data_oe = 1'b0;
        case (r_mode)
            MODE_BIDIR: port_data_oe = ~r_ack_prev;
            default:    port_data_oe = (r_dir == PORT_OUTPUT);
        endcase
    end

    assign port_data_out = (w_out_hs && !w_out_empty) ? w_out_head : r_pdo;
    assign cpu_read_data = r_rd_data;
    assign ibf           = ~w_in_empty;
    assign obf_n         = w_out_empty;
    assign intr          = r_intr_in | r_intr_out;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_kf8255_strobed_port.sv
// Directed bench for kf8255_strobed_port: a per-cycle vector table for mode 0
// and the mode 1 input handshake, then hand-written multi-cycle sequences.
module tb_kf8255_strobed_port;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       write_mode, direction_in, inte_write, inte_sel, inte_value;
    logic [1:0] mode_in;
    logic       cpu_read, cpu_write;
    logic [7:0] cpu_write_data, cpu_read_data, port_data_in, port_data_out;
    logic       port_data_oe, stb_n, ack_n, ibf, obf_n, intr, overrun;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    kf8255_strobed_port #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset_n(reset_n), .write_mode(write_mode), .mode_in(mode_in),
        .direction_in(direction_in), .inte_write(inte_write), .inte_sel(inte_sel),
        .inte_value(inte_value), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
        .port_data_in(port_data_in), .port_data_out(port_data_out),
        .port_data_oe(port_data_oe), .stb_n(stb_n), .ack_n(ack_n), .ibf(ibf),
        .obf_n(obf_n), .intr(intr), .overrun(overrun)
    );

    typedef struct packed {
        logic       wm;  logic [1:0] mode; logic dir;
        logic       iw;  logic isel; logic ival;
        logic       rd;  logic wr;
        logic [7:0] wdata; logic [7:0] pdin;
        logic       stb; logic ack;
        logic [7:0] e_rdd; logic [7:0] e_pdo;
        logic       e_oe; logic e_ibf; logic e_obfn; logic e_intr; logic e_ovr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rdd"},  cpu_read_data, 8'h00);
        chk({tag, ".pdo"},  port_data_out, 8'h00);
        chk({tag, ".oe"},   port_data_oe, 1'b0);
        chk({tag, ".ibf"},  ibf, 1'b0);
        chk({tag, ".obfn"}, obf_n, 1'b1);
        chk({tag, ".intr"}, intr, 1'b0);
        chk({tag, ".ovr"},  overrun, 1'b0);
    endtask

    task automatic set_mode(input logic [1:0] m, input logic d);
        write_mode = 1'b1; mode_in = m; direction_in = d;
        @(negedge clock);
        write_mode = 1'b0;
    endtask

    task automatic set_inte(input logic sel, input logic val);
        inte_write = 1'b1; inte_sel = sel; inte_value = val;
        @(negedge clock);
        inte_write = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] d);
        cpu_write = 1'b1; cpu_write_data = d;
        @(negedge clock);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd();
        cpu_read = 1'b1;
        @(negedge clock);
        cpu_read = 1'b0;
    endtask

    task automatic pulse_stb(input logic [7:0] d, input int lo, input int hi);
        port_data_in = d; stb_n = 1'b0;
        repeat (lo) @(negedge clock);
        stb_n = 1'b1;
        repeat (hi) @(negedge clock);
    endtask

    initial begin
        //             wm   mode  dir  iw   isel ival rd   wr   wdata  pdin   stb  ack   rdd    pdo    oe   ibf  obfn intr ovr
        vecs[0]  = '{1'b1,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b1,1'b1, 8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b1,1'b1, 8'hA5,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1, 8'h5A,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b1,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1, 8'h5A,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,2'd1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1, 8'h5A,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b1, 8'h5A,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b1, 8'h5A,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b1, 8'h5A,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[8]  = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b1, 8'h5A,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b0,1'b1, 8'h5A,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b1,1'b1, 8'h5A,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b1,1'b1, 8'h5A,8'h00,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[12] = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h3C,1'b1,1'b1, 8'h5A,8'h00,1'b0,1'b1,1'b1,1'b1,1'b0};
        vecs[13] = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,8'h3C,1'b1,1'b1, 8'h3C,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0,2'd1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,8'h99,1'b1,1'b1, 8'h3C,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[15] = '{1'b1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h99,1'b1,1'b1, 8'h3C,8'h00,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[16] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'hC3,8'h99,1'b1,1'b1, 8'h3C,8'hC3,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[17] = '{1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h99,1'b1,1'b1, 8'h3C,8'hC3,1'b1,1'b0,1'b1,1'b0,1'b0};

        reset_n = 1'b0;
        write_mode = 1'b0; mode_in = 2'd0; direction_in = 1'b1;
        inte_write = 1'b0; inte_sel = 1'b0; inte_value = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_write_data = 8'h00;
        port_data_in = 8'h00; stb_n = 1'b1; ack_n = 1'b1;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Mode 0 input/output and the mode 1 input handshake, cycle by cycle.
        for (int i = 0; i < NV; i++) begin
            write_mode = vecs[i].wm; mode_in = vecs[i].mode; direction_in = vecs[i].dir;
            inte_write = vecs[i].iw; inte_sel = vecs[i].isel; inte_value = vecs[i].ival;
            cpu_read = vecs[i].rd; cpu_write = vecs[i].wr; cpu_write_data = vecs[i].wdata;
            port_data_in = vecs[i].pdin; stb_n = vecs[i].stb; ack_n = vecs[i].ack;
            @(negedge clock);
            chk($sformatf("v%0d.rdd", i),  cpu_read_data, vecs[i].e_rdd);
            chk($sformatf("v%0d.pdo", i),  port_data_out, vecs[i].e_pdo);
            chk($sformatf("v%0d.oe", i),   port_data_oe,  vecs[i].e_oe);
            chk($sformatf("v%0d.ibf", i),  ibf,           vecs[i].e_ibf);
            chk($sformatf("v%0d.obfn", i), obf_n,         vecs[i].e_obfn);
            chk($sformatf("v%0d.intr", i), intr,          vecs[i].e_intr);
            chk($sformatf("v%0d.ovr", i),  overrun,       vecs[i].e_ovr);
        end
        write_mode = 1'b0; inte_write = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;

        // Mode 1 output, depth 4: fifth write dropped, acks drain in order.
        set_mode(2'd1, 1'b0);
        chk("m1o.oe", port_data_oe, 1'b1);
        chk("m1o.obfn0", obf_n, 1'b1);
        set_inte(1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) cpu_wr(8'(i));
        chk("m1o.ovr", overrun, 1'b1);
        chk("m1o.obfn", obf_n, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("m1o.pdo%0d", k), port_data_out, 8'(k));
            ack_n = 1'b0;
            repeat (4) @(negedge clock);
            if (k == 4) begin
                chk("m1o.obfn_last", obf_n, 1'b1);
                chk("m1o.intr_pre", intr, 1'b0);
                chk("m1o.pdo_hold", port_data_out, 8'h04);
            end
            ack_n = 1'b1;
            repeat (4) @(negedge clock);
            chk($sformatf("m1o.intr%0d", k), intr, (k == 4) ? 1'b1 : 1'b0);
        end
        cpu_wr(8'h77);
        chk("m1o.intr_clr", intr, 1'b0);
        chk("m1o.obfn_new", obf_n, 1'b0);
        chk("m1o.pdo_new", port_data_out, 8'h77);

        // Mode 2: ack drives OE after three edges; concurrent strobe still captured.
        set_mode(2'd2, 1'b0);
        chk("m2.oe0", port_data_oe, 1'b0);
        chk("m2.ovr", overrun, 1'b0);
        ack_n = 1'b0; stb_n = 1'b0; port_data_in = 8'h9E;
        repeat (2) @(negedge clock);
        chk("m2.oe_e2", port_data_oe, 1'b0);
        @(negedge clock);
        chk("m2.oe_e3", port_data_oe, 1'b1);
        chk("m2.ibf", ibf, 1'b1);
        ack_n = 1'b1; stb_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("m2.oe_hold", port_data_oe, 1'b1);
        @(negedge clock);
        chk("m2.oe_off", port_data_oe, 1'b0);
        cpu_rd();
        chk("m2.rdd", cpu_read_data, 8'h9E);
        chk("m2.ibf_clr", ibf, 1'b0);

        // Full input buffer: strobe push and CPU pop on the same edge.
        set_mode(2'd1, 1'b1);
        for (int i = 0; i < 4; i++) pulse_stb(8'h10 + 8'(i), 4, 4);
        chk("full.ibf", ibf, 1'b1);
        port_data_in = 8'h14; stb_n = 1'b0;
        repeat (2) @(negedge clock);
        cpu_read = 1'b1;
        @(negedge clock);
        cpu_read = 1'b0;
        chk("full.rdd", cpu_read_data, 8'h10);
        chk("full.ovr", overrun, 1'b0);
        stb_n = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 1; i <= 4; i++) begin
            cpu_rd();
            chk($sformatf("full.rd%0d", i), cpu_read_data, 8'h10 + 8'(i));
        end
        chk("full.ibf_empty", ibf, 1'b0);
        for (int i = 0; i < 5; i++) pulse_stb(8'h20 + 8'(i), 4, 4);
        chk("full.ovr_drop", overrun, 1'b1);
        cpu_rd();
        chk("full.rd_after_drop", cpu_read_data, 8'h20);

        // Asynchronous reset mid-strobe, then write_mode with intr pending.
        port_data_in = 8'h55; stb_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        stb_n = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("rel.ibf", ibf, 1'b0);
        set_mode(2'd1, 1'b1);
        set_inte(1'b0, 1'b1);
        pulse_stb(8'h66, 5, 4);
        chk("pend.ibf", ibf, 1'b1);
        chk("pend.intr", intr, 1'b1);
        set_mode(2'd1, 1'b1);
        chk("wm.intr", intr, 1'b0);
        chk("wm.ibf", ibf, 1'b0);
        chk("wm.ovr", overrun, 1'b0);
        chk("wm.pdo", port_data_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kf8255_strobed_port.md
# kf8255_strobed_port

Parametrised strobed-handshake port for the KF8255 family, successor to the single-nibble group control logic. Holds one port's mode/direction configuration plus the mode 1/2 handshake machinery (STB/IBF, OBF/ACK, INTE/INTR), with a configurable-depth buffer in each direction. Sits between the KF8255 bus interface (decoded control-word writes, port read/write strobes) and the external port pins.

## Interface

- DATA_WIDTH, 8, port data width
- FIFO_DEPTH, 1, entries per direction buffer (power of two, 1..16); 1 gives classic 8255 behaviour
- SYNC_STAGES, 2, synchroniser flops on stb_n/ack_n (>=2)

Ports:

- clock  in  1  single system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- write_mode  in  1  one-cycle pulse: load mode_in/direction_in
- mode_in  in  2  0 = basic, 1 = strobed, 2/3 = bidirectional
- direction_in  in  1  1 = input, 0 = output (mode 0/1 only)
- inte_write  in  1  one-cycle pulse: load inte_in/inte_out from inte_value
- inte_sel  in  1  0 = input-side INTE, 1 = output-side INTE
- inte_value  in  1  new INTE bit
- cpu_read  in  1  one-cycle pulse: CPU port read
- cpu_write  in  1  one-cycle pulse: CPU port write
- cpu_write_data  in  DATA_WIDTH  write data
- cpu_read_data  out  DATA_WIDTH  registered read data
- port_data_in  in  DATA_WIDTH  pin input
- port_data_out  out  DATA_WIDTH  pin output
- port_data_oe  out  1  pin output enable
- stb_n  in  1  async strobe
- ack_n  in  1  async acknowledge
- ibf  out  1  input buffer non-empty
- obf_n  out  1  low while output buffer non-empty
- intr  out  1  interrupt request
- overrun  out  1  sticky: input push or CPU write dropped on full buffer

## Operation

- Reset: mode 0, direction input, both INTE 0, buffers empty, cpu_read_data 0, port_data_out 0, port_data_oe 0, ibf 0, obf_n 1, intr 0, overrun 0.
- write_mode: loads config, flushes both buffers, clears INTE, intr, overrun, port_data_out; all same edge. Takes priority over every other input that cycle.
- Mode 0: input — cpu_read_data samples port_data_in every cycle; output — cpu_write loads port_data_out, port_data_oe = 1. No handshake; ibf 0, obf_n 1, intr 0.
- Strobed input (mode 1 input, mode 2): synchronised stb_n falling edge pushes port_data_in (sampled at the synchroniser-output edge cycle) into input buffer; ibf = non-empty. Synchronised stb_n rising edge with inte_in = 1 and buffer non-empty sets intr. cpu_read pops head into cpu_read_data and clears input-side intr; read when empty returns last value, no state change.
- Strobed output (mode 1 output, mode 2): cpu_write pushes; obf_n = empty; port_data_out = buffer head. Synchronised ack_n falling edge pops. Synchronised ack_n rising edge with inte_out = 1 and buffer empty sets intr; cpu_write clears output-side intr.
- port_data_oe: mode 1 output = 1; mode 2 = synchronised ack_n low; mode 1 input = 0.
- intr = OR of input-side and output-side requests.
- Full buffer: pop before push — simultaneous pop and push on full both succeed; push on full without pop dropped, overrun set.

## Timing

- Pin edge on stb_n/ack_n acted upon SYNC_STAGES+1 rising edges later (3 with default).
- cpu_read_data valid the cycle after cpu_read; ibf/obf_n/intr are registered, updated same edge as buffer change.
- Strobes of width < SYNC_STAGES+1 cycles not guaranteed captured.
- reset_n assertion mid-handshake returns all outputs to reset values immediately; synchronisers reset to 1 so no spurious edge on release.

## Structure

- Package kf8255_port_pkg: mode enum (MODE_BASIC, MODE_STROBED, MODE_BIDIR), PORT_INPUT/PORT_OUTPUT constants, shared with existing KF8255 definitions.
- Sub-module kf8255_sync_fifo (DATA_WIDTH, FIFO_DEPTH; push, pop, flush, full, empty, head), instantiated twice.

## Test plan

- Reset then mode 0 input, port_data_in = 8'hA5 -> cpu_read_data = 8'hA5 after one cycle; ibf 0, intr 0.
- Mode 1 input, inte_in 1, stb_n pulse (5 cycles) with 8'h3C -> ibf 1 at 3rd edge after fall, intr 1 after rise; cpu_read -> cpu_read_data 8'h3C, ibf 0, intr 0.
- Mode 1 output, FIFO_DEPTH 4, writes 8'h01..8'h05 -> fifth dropped, overrun 1; four ack_n pulses present 8'h01..8'h04 in order, obf_n 1 after last, intr 1 after last ack rise.
- Mode 2: ack_n low -> port_data_oe 1 after 3 edges, 0 after release; concurrent stb_n capture unaffected.
- Full input buffer with stb_n fall and cpu_read same cycle -> both succeed, no overrun.
- reset_n low mid-strobe, then write_mode during pending intr -> all outputs at reset/cleared values, no spurious push after release.
